// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// I-type, beq and bne, and handshakes with a variable-latency unified
// memory via mem_req/mem_ready. Outputs are Moore-style (state plus
// mem_ready in FETCH and Zero/funct3 in BRANCH).
// Optional feature: define ILLEGAL_TRAP_EN to send unsupported opcodes and
// unsupported branch funct3 values to a sticky TRAP state with illegal=1.
// Without it such instructions retire as a NOP and illegal is tied 0.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  // The control word is width-independent; the datapath it drives must be RV32.
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("multicycle_ctrl expects a 32-bit datapath");
  end

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] TRAP     = 4'd10;
`endif

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state;
  logic [3:0] state_next;

  // ALU operation for R/I-type; only R-type funct3=000 with funct7b5 subtracts
  // (I-type addi never subtracts, whatever imm[10] happens to be).
  function automatic logic [2:0] alu_decode(input logic [6:0] opc,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [2:0] res;
    case (f3)
      3'b000:  res = (opc == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  res = ALU_SLT;
      3'b110:  res = ALU_OR;
      3'b111:  res = ALU_AND;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // State register; synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state selection; memory states hold until mem_ready.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
`ifdef ILLEGAL_TRAP_EN
          OP_B:         state_next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          default:      state_next = TRAP;
`else
          OP_B:         state_next = BRANCH;
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end

  // Control word per state; anything not driven in a state stays 0 / add.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LW) ? 2'b00 : 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(op, funct3, funct7b5);
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(op, funct3, funct7b5);
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        // beq takes on Zero, bne on !Zero; other funct3 never redirect.
        PCWrite    = (funct3[2:1] == 2'b00) ? (Zero ^ funct3[0]) : 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction table, a reset-during-stall
// sequence and randomized instructions, each expanded by an instruction-level
// model into the expected per-cycle control words.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  logic [17:0] act;
  assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal};

  typedef struct {
    logic        mr;
    logic        z;
    logic [17:0] exp;
    string       tag;
  } cyc_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         fw;
    int         dw;
    logic       z;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [17:0] ov(input bit req, input bit mw, input bit adr,
                                     input bit irw, input bit pcw, input bit rw,
                                     input logic [1:0] imm, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] res,
                                     input logic [2:0] alu, input bit ill = 1'b0);
    return {req, mw, adr, irw, pcw, rw, imm, a, b, res, alu, ill};
  endfunction

  function automatic cyc_t mk(input logic mr, input logic z, input logic [17:0] e,
                              input string tag);
    cyc_t c;
    c.mr = mr; c.z = z; c.exp = e; c.tag = tag;
    return c;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(1, 0));
  endfunction

  // ALU operation an R/I instruction should request, from the ISA rules.
  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    if (f3 == 3'b000) return (o == OP_R && f7) ? SUB : ADD;
    if (f3 == 3'b010) return SLT;
    if (f3 == 3'b110) return OR_;
    if (f3 == 3'b111) return AND_;
    return ADD;
  endfunction

  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic mr, input logic z, input logic [17:0] e,
                       input string tag);
    @(negedge clk);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = mr; Zero = z;
    #1;
    nvec++;
    if (act !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expand one instruction into the control words each of its cycles should show.
  task automatic run_instr(input vec_t v);
    cyc_t q[$];
    bit trap_it;
    logic taken;
    logic [17:0] fetch_w;
    fetch_w = ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, ADD);
    trap_it = 1'b0;
    for (int i = 0; i < v.fw; i++) q.push_back(mk(1'b0, rb(), fetch_w, {v.name, ":fetch_wait"}));
    q.push_back(mk(1'b1, rb(), ov(1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, ADD), {v.name, ":fetch"}));
    q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, ADD), {v.name, ":decode"}));
    if (v.op == OP_LW || v.op == OP_SW) begin
      q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 0, (v.op == OP_LW) ? 2'b00 : 2'b01,
                                    2'b10, 2'b01, 2'b00, ADD), {v.name, ":memadr"}));
      for (int i = 0; i <= v.dw; i++)
        q.push_back(mk(logic'(i == v.dw), rb(),
                       ov(1, v.op == OP_SW, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ADD),
                       {v.name, ":access"}));
      if (v.op == OP_LW)
        q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, ADD), {v.name, ":memwb"}));
    end else if (v.op == OP_R || v.op == OP_I) begin
      q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (v.op == OP_I) ? 2'b01 : 2'b00,
                                    2'b00, exp_alu(v.op, v.f3, v.f7)), {v.name, ":exec"}));
      q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, ADD), {v.name, ":aluwb"}));
    end else if (v.op == OP_B) begin
      if (TRAP_BUILD && v.f3 != 3'b000 && v.f3 != 3'b001) trap_it = 1'b1;
      else begin
        if (v.f3 == 3'b000)      taken = v.z;
        else if (v.f3 == 3'b001) taken = !v.z;
        else                     taken = 1'b0;
        q.push_back(mk(rb(), v.z, ov(0, 0, 0, 0, taken, 0, 2'b00, 2'b10, 2'b00, 2'b00, SUB), {v.name, ":branch"}));
      end
    end else begin
      trap_it = TRAP_BUILD;
    end
    if (trap_it)
      for (int i = 0; i < 3; i++)
        q.push_back(mk(rb(), rb(), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ADD, 1'b1), {v.name, ":trap"}));
    foreach (q[i]) apply(v.op, v.f3, v.f7, q[i].mr, q[i].z, q[i].exp, q[i].tag);
    if (trap_it) do_reset();
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [6:0] ops[6];
  logic [17:0] fetch_w, memrd_w;

  initial begin
    tbl.push_back('{"fetch3_add", OP_R,  3'b000, 1'b0, 3, 0, 1'b0});
    tbl.push_back('{"r_sub",      OP_R,  3'b000, 1'b1, 0, 0, 1'b0});
    tbl.push_back('{"lw_wait2",   OP_LW, 3'b010, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{"sw",         OP_SW, 3'b010, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"sw_wait1",   OP_SW, 3'b010, 1'b1, 1, 1, 1'b0});
    tbl.push_back('{"beq_z1",     OP_B,  3'b000, 1'b0, 0, 0, 1'b1});
    tbl.push_back('{"beq_z0",     OP_B,  3'b000, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"bne_z1",     OP_B,  3'b001, 1'b0, 0, 0, 1'b1});
    tbl.push_back('{"bne_z0",     OP_B,  3'b001, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"b_f3_100",   OP_B,  3'b100, 1'b0, 0, 0, 1'b1});
    tbl.push_back('{"addi_f7",    OP_I,  3'b000, 1'b1, 0, 0, 1'b0});
    tbl.push_back('{"ori",        OP_I,  3'b110, 1'b0, 1, 0, 1'b0});
    tbl.push_back('{"r_slt",      OP_R,  3'b010, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"r_and",      OP_R,  3'b111, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"r_xor_add",  OP_R,  3'b100, 1'b1, 0, 0, 1'b0});
    tbl.push_back('{"ill_7f",     7'h7f, 3'b000, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{"lw_after",   OP_LW, 3'b010, 1'b0, 0, 0, 1'b0});

    fetch_w = ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, ADD);
    memrd_w = ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ADD);

    do_reset();
    apply(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, fetch_w, "reset_fetch");

    foreach (tbl[i]) run_instr(tbl[i]);

    // lw stalled in its data read, then reset: the access is dropped.
    apply(OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ov(1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, ADD), "stall:fetch");
    apply(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, ADD), "stall:decode");
    apply(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, ADD), "stall:memadr");
    apply(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, memrd_w, "stall:memread0");
    apply(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, memrd_w, "stall:memread1");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (act !== memrd_w) begin
      nerr++;
      $display("FAIL stall:in_reset: got %h want %h", act, memrd_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++;
    if (act !== fetch_w) begin
      nerr++;
      $display("FAIL stall:after_reset: got %h want %h", act, fetch_w);
    end

    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I; ops[4] = OP_B; ops[5] = 7'h00;
    for (int n = 0; n < 300; n++) begin
      rv.name = "rand";
      rv.op   = ops[$urandom_range(5, 0)];
      if (rv.op == 7'h00) rv.op = 7'($urandom);
      rv.f3   = 3'($urandom);
      rv.f7   = rb();
      rv.fw   = int'($urandom_range(3, 0));
      rv.dw   = int'($urandom_range(3, 0));
      rv.z    = rb();
      run_instr(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I datapath: sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the immediate-extender select, ALU operand muxes, ALU operation, register-file and memory enables, and the PC update.
- Handshakes with a variable-latency unified instruction/data memory through req/ready.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, bne.

Parameters:
- DATA_WIDTH, 32, datapath width. Used only for consistency checks; the control outputs themselves are fixed-width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write strobe, valid only with mem_req
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- IRWrite  out  1  load the instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write enable
- ImmSrc  out  2  extender select: 00=I, 01=S, 10=B
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALUResult
- ALUControl  out  3  000=add, 001=sub, 010=and, 011=or, 101=slt
- illegal  out  1  illegal-opcode flag (optional feature only; otherwise tied 0)

Behaviour:
- Moore FSM; outputs are combinational from state plus the inputs named below. Any output not listed for a state is 0; ALUControl not listed = add.
- While rst_n=0 at an edge: state <= FETCH. Outputs are not separately gated, so the FETCH outputs (mem_req=1, AdrSrc=0, etc.) appear as soon as state=FETCH.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=mem_ready and PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (branch target to ALUOut).
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; any other op -> FETCH.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for lw, 01 for sw.
  - Next state: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Holds until mem_ready, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from the ALU decoder -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUControl from the ALU decoder -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0] when funct3 is 000 or 001; PCWrite=0 for any other funct3.
  - Next state -> FETCH.
- ALU decoder, by funct3:
  - 000: sub only if op=0110011 and funct7b5=1; add otherwise.
  - 010: slt. 110: or. 111: and. All other funct3: add.
- Memory request rules: mem_req, AdrSrc and MemWrite stay stable while waiting for mem_ready. A mem_ready arriving in a non-memory state is ignored.
- Reset during a stall: the access is abandoned and the next cycle is FETCH.
- Latency:
  - R/I-type: 4 cycles.
  - lw: 5 cycles; sw: 4 cycles.
  - Branch: 3 cycles.
  - Each memory access adds (wait cycles) on top.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - An unsupported op in DECODE, or a branch funct3 other than 000/001, goes to a TRAP state.
  - TRAP asserts no enables and holds illegal=1 until reset. TRAP is sticky; only rst_n exits it.
- ILLEGAL_TRAP_EN undefined:
  - Such instructions complete as a NOP back to FETCH.
  - No TRAP state is built; illegal is tied 0.

Test Plan:
- Reset, then mem_ready held 0 for 3 cycles -> mem_req=1, AdrSrc=0 throughout. IRWrite and PCWrite pulse for exactly 1 cycle when mem_ready=1, then the FSM is in DECODE.
- R-type sub (op=0110011, funct3=000, funct7b5=1) with zero-wait memory:
  - EXECR: ALUControl=001.
  - ALUWB: RegWrite=1.
  - Back in FETCH on cycle 5.
- lw (op=0000011) with 2 wait cycles on the data read:
  - MEMADR: ImmSrc=00.
  - MEMREAD: mem_req=1 and AdrSrc=1 held for 3 cycles.
  - MEMWB: ResultSrc=01, RegWrite=1.
- sw (op=0100011): MEMADR ImmSrc=01; MEMWRITE MemWrite=1; RegWrite stays 0 throughout.
- Branches:
  - beq with Zero=1 -> PCWrite=1 in BRANCH.
  - bne (funct3=001) with Zero=1 -> PCWrite=0.
  - bne with Zero=0 -> PCWrite=1.
- op=1111111 -> with ILLEGAL_TRAP_EN: illegal=1 and no enables until rst_n=0 for 1 cycle. Without it: returns to FETCH with no RegWrite or MemWrite.
